// File: rtl/sensor_input_conditioner_pkg.sv
// Shared constants for the sensor input conditioner: channel count and debounce
// lengths for the board build and the fast simulation build.
package sensor_input_conditioner_pkg;

  localparam int N_SENS           = 5;
  localparam int DEB_CYCLES_BOARD = 50000;
  localparam int DEB_CYCLES_SIM   = 4;
  localparam int CNT_W_BOARD      = 16;

  // Width of the post-reset settle counter, which must reach DEB_CYCLES+2.
  function automatic int settle_width(input int deb_cycles);
    return $clog2(deb_cycles + 3);
  endfunction

endpackage

// File: rtl/sensor_input_conditioner_if.sv
// Raw input lines and conditioned outputs of the sensor input conditioner.
// The master drives raw lines; the slave (the conditioner) drives the clean side.
interface sensor_input_conditioner_if #(
  parameter int N_SENS = sensor_input_conditioner_pkg::N_SENS
);

  logic [N_SENS-1:0] sen_raw;
  logic              button_raw;
  logic [N_SENS-1:0] sen_stable;
  logic              button_level;
  logic              button_press;
  logic              mute;
  logic              inputs_valid;

  modport master (
    output sen_raw, button_raw,
    input  sen_stable, button_level, button_press, mute, inputs_valid
  );

  modport slave (
    input  sen_raw, button_raw,
    output sen_stable, button_level, button_press, mute, inputs_valid
  );

endinterface

// File: rtl/sensor_input_conditioner_debounce.sv
// One conditioner channel: 2-flop synchroniser followed by a debounce counter that
// accepts a new level only after DEB_CYCLES consecutive mismatching cycles.
module debounce_cell
  import sensor_input_conditioner_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_BOARD,
  parameter int CNT_W      = CNT_W_BOARD
) (
  input  logic clk,
  input  logic rst,
  input  logic d_async,
  output logic q_stable
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

  logic             meta_q,   meta_d;
  logic             sync_q,   sync_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q,    cnt_d;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no path can infer a latch.
    meta_d   = d_async;
    sync_d   = meta_q;
    stable_d = stable_q;
    cnt_d    = '0;
    // The count only grows across an unbroken mismatch run; reaching the last
    // count commits the new level and clears, so the counter can never wrap.
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= meta_d;
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
    end
  end

  assign q_stable = stable_q;

endmodule

// File: rtl/sensor_input_conditioner.sv
// Synchronises and debounces the gas-sensor lines and the push button, then derives
// the press pulse, the mute toggle and the post-reset inputs_valid flag.
module sensor_input_conditioner #(
  parameter int N_SENS         = sensor_input_conditioner_pkg::N_SENS,
  parameter int DEB_CYCLES     = sensor_input_conditioner_pkg::DEB_CYCLES_BOARD,
  parameter int CNT_W          = sensor_input_conditioner_pkg::CNT_W_BOARD,
  parameter int BTN_ACTIVE_LOW = 1
) (
  input logic                       clk,
  input logic                       rst,
  sensor_input_conditioner_if.slave bus
);

  import sensor_input_conditioner_pkg::*;

  localparam int               N_CHAN      = N_SENS + 1;
  localparam int               SET_W       = settle_width(DEB_CYCLES);
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(DEB_CYCLES + 2);

  logic [N_CHAN-1:0] raw_chan;
  logic [N_CHAN-1:0] stable_chan;
  logic              btn_pressed_raw;
  logic              button_level;

  logic              level_prev_q, level_prev_d;
  logic              press_q,      press_d;
  logic              mute_q,       mute_d;
  logic              valid_q,      valid_d;
  logic [SET_W-1:0]  settle_cnt_q, settle_cnt_d;

  // The button is normalised to 1 = pressed ahead of its synchroniser so that all
  // N_CHAN channels are identical; the button occupies the top channel.
  always_comb begin
    btn_pressed_raw = (BTN_ACTIVE_LOW != 0) ? ~bus.button_raw : bus.button_raw;
    raw_chan        = {btn_pressed_raw, bus.sen_raw};
  end

  for (genvar i = 0; i < N_CHAN; i++) begin : g_chan
    debounce_cell #(
      .DEB_CYCLES (DEB_CYCLES),
      .CNT_W      (CNT_W)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .d_async  (raw_chan[i]),
      .q_stable (stable_chan[i])
    );
  end

  assign button_level = stable_chan[N_SENS];

  always_comb begin
    level_prev_d = button_level;
    press_d      = button_level & ~level_prev_q;
    mute_d       = mute_q ^ press_d;
    settle_cnt_d = settle_cnt_q;
    valid_d      = valid_q;
    // Once valid the settle counter freezes, so it never needs to wrap.
    if (!valid_q) begin
      if (settle_cnt_q == SETTLE_LAST) begin
        valid_d = 1'b1;
      end else begin
        settle_cnt_d = settle_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
      mute_q       <= 1'b0;
      valid_q      <= 1'b0;
      settle_cnt_q <= '0;
    end else begin
      level_prev_q <= level_prev_d;
      press_q      <= press_d;
      mute_q       <= mute_d;
      valid_q      <= valid_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  assign bus.sen_stable   = stable_chan[N_SENS-1:0];
  assign bus.button_level = button_level;
  assign bus.button_press = press_q;
  assign bus.mute         = mute_q;
  assign bus.inputs_valid = valid_q;

endmodule

// File: tb/tb_sensor_input_conditioner.sv
// Self-checking bench for sensor_input_conditioner: directed timing checks from the
// behavioural rules plus randomized traffic compared against a reference model.
module tb_sensor_input_conditioner;

  import sensor_input_conditioner_pkg::*;

  localparam int DEB = DEB_CYCLES_SIM;
  localparam int NS  = N_SENS;
  localparam int NC  = NS + 1;
  localparam int P   = DEB + 1;   // edges from a raw change to the debounced change

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sensor_input_conditioner_if #(.N_SENS(NS)) bus ();

  sensor_input_conditioner #(
    .N_SENS         (NS),
    .DEB_CYCLES     (DEB),
    .CNT_W          (16),
    .BTN_ACTIVE_LOW (1)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- reference model ----------------
  // A channel's clean level flips once the synchronised input (raw as sampled two
  // edges earlier) has disagreed with it for DEB consecutive edges.
  logic [NC-1:0] samp_q[$];   // raw samples, newest first
  logic [NC-1:0] m_stable;
  logic          m_rose, m_press, m_mute, m_valid;
  int            m_edge;

  always @(posedge clk) begin : model
    logic [NC-1:0] raw_now;
    logic [NC-1:0] nxt;
    logic          all_flip;
    if (rst) begin
      samp_q = {};
      for (int i = 0; i < DEB + 2; i++) samp_q.push_back('0);
      m_stable = '0;
      m_rose   = 1'b0;
      m_press  = 1'b0;
      m_mute   = 1'b0;
      m_valid  = 1'b0;
      m_edge   = -1;
    end else begin
      m_edge++;
      raw_now = {~bus.button_raw, bus.sen_raw};
      nxt     = m_stable;
      for (int c = 0; c < NC; c++) begin
        all_flip = 1'b1;
        for (int k = 1; k <= DEB; k++)
          if (samp_q[k][c] == m_stable[c]) all_flip = 1'b0;
        if (all_flip) nxt[c] = ~m_stable[c];
      end
      m_press = m_rose;
      if (m_press) m_mute = ~m_mute;
      m_rose   = nxt[NS] & ~m_stable[NS];
      m_stable = nxt;
      m_valid  = (m_edge >= DEB + 2);
      samp_q.push_front(raw_now);
      void'(samp_q.pop_back());
    end
  end

  function automatic logic [NS+3:0] dut_vec();
    return {bus.inputs_valid, bus.mute, bus.button_press, bus.button_level, bus.sen_stable};
  endfunction

  function automatic logic [NS+3:0] mdl_vec();
    return {m_valid, m_mute, m_press, m_stable[NS], m_stable[NS-1:0]};
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1;
    bus.sen_raw    = '0;
    bus.button_raw = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got %h expected %h", dut_vec(), {(NS+4){1'b0}});
    end
    rst = 1'b0;   // next posedge is release edge 0
  endtask

  task automatic test_valid();
    logic exp_v;
    for (int j = 0; j <= DEB + 4; j++) begin
      @(negedge clk);
      exp_v = (j >= DEB + 2);
      n_cmp++;
      if (bus.inputs_valid !== exp_v) begin
        n_bad++;
        $display("FAIL valid_edge%0d: got %b expected %b", j, bus.inputs_valid, exp_v);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL model_valid: got %h expected %h at edge %0d", dut_vec(), mdl_vec(), m_edge);
      end
    end
  endtask

  task automatic test_rise();
    localparam int H = DEB + 4;
    logic [NS-1:0] exp_s;
    for (int j = 0; j < H + P + 3; j++) begin
      bus.sen_raw[2] = (j < H);
      @(negedge clk);
      exp_s    = '0;
      exp_s[2] = (j >= P) && (j < H + P);
      n_cmp++;
      if (bus.sen_stable !== exp_s) begin
        n_bad++;
        $display("FAIL rise_edge%0d: got %b expected %b", j, bus.sen_stable, exp_s);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL model_rise: got %h expected %h at edge %0d", dut_vec(), mdl_vec(), m_edge);
      end
    end
  endtask

  task automatic test_glitch();
    logic exp_b;
    // glitch of DEB-1 cycles, one low cycle, then a DEB-cycle pulse
    for (int j = 0; j < 3 * DEB + 4; j++) begin
      bus.sen_raw[0] = (j < DEB - 1) || (j >= DEB && j < 2 * DEB);
      @(negedge clk);
      exp_b = (j >= DEB + P) && (j < 2 * DEB + P);
      n_cmp++;
      if (bus.sen_stable[0] !== exp_b) begin
        n_bad++;
        $display("FAIL glitch_edge%0d: got %b expected %b", j, bus.sen_stable[0], exp_b);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL model_glitch: got %h expected %h at edge %0d", dut_vec(), mdl_vec(), m_edge);
      end
    end
  endtask

  task automatic test_button();
    logic [2:0] exp_b, got_b;
    // pressed 20, released 20, pressed 20, released 20 (button is active low)
    for (int j = 0; j < 80; j++) begin
      bus.button_raw = ~((j < 20) || (j >= 40 && j < 60));
      @(negedge clk);
      exp_b[2] = (j >= P && j < 20 + P) || (j >= 40 + P && j < 60 + P);
      exp_b[1] = (j == P + 1) || (j == 40 + P + 1);
      exp_b[0] = (j >= P + 1) && (j < 40 + P + 1);
      got_b    = {bus.button_level, bus.button_press, bus.mute};
      n_cmp++;
      if (got_b !== exp_b) begin
        n_bad++;
        $display("FAIL button_edge%0d: got lvl/press/mute %b expected %b", j, got_b, exp_b);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL model_button: got %h expected %h at edge %0d", dut_vec(), mdl_vec(), m_edge);
      end
    end
  endtask

  task automatic test_parallel();
    localparam int H = DEB + 4;
    logic [NS-1:0] pat, exp_s;
    pat = NS'(5'b10101);
    for (int j = 0; j < H + P + 2; j++) begin
      bus.sen_raw = (j < H) ? pat : '0;
      @(negedge clk);
      exp_s = (j >= P && j < H + P) ? pat : '0;
      n_cmp++;
      if (bus.sen_stable !== exp_s) begin
        n_bad++;
        $display("FAIL parallel_edge%0d: got %b expected %b", j, bus.sen_stable, exp_s);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL model_parallel: got %h expected %h at edge %0d", dut_vec(), mdl_vec(), m_edge);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic exp_v, exp_b;
    bus.sen_raw[4] = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;   // reset lands on edge 3 of the count
    @(negedge clk);
    n_cmp++;
    if (dut_vec() !== '0) begin
      n_bad++;
      $display("FAIL reset_mid_outputs: got %h expected %h", dut_vec(), {(NS+4){1'b0}});
    end
    rst = 1'b0;
    for (int j = 0; j <= DEB + 4; j++) begin
      @(negedge clk);
      exp_v = (j >= DEB + 2);
      exp_b = (j >= P);
      n_cmp++;
      if ({bus.inputs_valid, bus.sen_stable[4]} !== {exp_v, exp_b}) begin
        n_bad++;
        $display("FAIL reset_mid_edge%0d: got valid/sen4 %b%b expected %b%b",
                 j, bus.inputs_valid, bus.sen_stable[4], exp_v, exp_b);
      end
      n_cmp++;
      if (dut_vec() !== mdl_vec()) begin
        n_bad++;
        $display("FAIL model_reset_mid: got %h expected %h at edge %0d", dut_vec(), mdl_vec(), m_edge);
      end
    end
    bus.sen_raw[4] = 1'b0;
  endtask

  task automatic test_random();
    int hold;
    for (int seg = 0; seg < 70; seg++) begin
      bus.sen_raw    = NS'($urandom);
      bus.button_raw = 1'($urandom_range(0, 1));
      hold           = $urandom_range(1, 2 * DEB + 2);
      if ($urandom_range(0, 24) == 0) rst = 1'b1;
      for (int j = 0; j < hold; j++) begin
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if (dut_vec() !== mdl_vec()) begin
          n_bad++;
          $display("FAIL model_random: got %h expected %h at edge %0d", dut_vec(), mdl_vec(), m_edge);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_valid();
    test_rise();
    test_glitch();
    test_button();
    test_parallel();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
